instr_seq: RTL and testbench
============================

INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 Parameter: ICNT_W, default 16, width of retired-instruction counter.
REQ-002 clk  input  1  single system clock, all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 run  input  1  level; 1 = sequence instructions, 0 = pause at next instruction boundary.
REQ-005 ir  input  8  instruction register contents; ir[7:4] = opcode.
REQ-006 in_valid  input  1  input device holds valid data.
REQ-007 out_ready  input  1  output device accepts data this cycle.
REQ-008 sm  output  1  cycle phase: 0 = fetch, 1 = execute.
REQ-009 nop, halt, in1, out1, mova, movb, movc, jmp, jz, add, sub, and1, not1, rsr, rsl, jc  output  1 each  one-hot decoded instruction lines.
REQ-010 busy  output  1  1 in FETCH or EXEC.
REQ-011 halted  output  1  1 in HALTED.
REQ-012 icount  output  ICNT_W  retired-instruction count.

Function
REQ-013 Opcode map (ir[7:4]) SHALL be: 0 NOP, 1 HALT, 2 IN, 3 OUT, 4 MOVA, 5 MOVB, 6 MOVC, 7 JMP, 8 JZ, 9 ADD, A SUB, B AND, C NOT, D RSR, E RSL, F JC; no illegal codes.
REQ-014 FSM states SHALL be IDLE, FETCH, EXEC, HALTED.
REQ-015 IDLE: sm=0, all instruction lines 0; run=1 -> FETCH next cycle, else stay.
REQ-016 FETCH: sm=0, all instruction lines 0, lasts exactly one cycle, always -> EXEC (IR loads on this edge).
REQ-017 EXEC: sm=1; exactly one instruction line SHALL be 1, decoded combinationally from current ir.
REQ-018 EXEC with IN: stay in EXEC while in_valid=0; complete on first cycle in_valid=1.
REQ-019 EXEC with OUT: stay in EXEC while out_ready=0; complete on first cycle out_ready=1.
REQ-020 EXEC with HALT: completes in one cycle -> HALTED.
REQ-021 EXEC with any other opcode: completes in one cycle.
REQ-022 On completion (not HALT): run=1 -> FETCH, run=0 -> IDLE.
REQ-023 run falling mid-instruction SHALL NOT abort it; pause takes effect only at completion.
REQ-024 HALTED: sm=1, halt=1, other lines 0, halted=1, busy=0; exits only by reset; run ignored.
REQ-025 icount SHALL increment by 1 on every completion edge including HALT, saturating at all-ones.
REQ-026 Stall cycles (IN/OUT waiting) SHALL NOT increment icount.
REQ-027 Instruction lines SHALL be glitch-free per cycle: derived only from registered state and ir.

Reset
REQ-028 rst_n=0 at a rising edge SHALL force IDLE, icount=0 regardless of state, including mid-stall and HALTED.
REQ-029 Output values during/after reset: sm=0, all instruction lines 0, busy=0, halted=0, icount=0.
REQ-030 Reset SHALL take priority over run, in_valid, out_ready on the same edge.

Structure
REQ-031 Opcode constants and FSM state encoding SHALL reside in a shared package used by instr_seq and the control-signal generator.
REQ-032 Opcode-to-one-hot decode SHALL be a sub-module op_decode (combinational, 4-bit in, 16 one-hot out); instr_seq gates its output by state.

Verification
REQ-033 Reset, run=1, ir=0x90 (ADD) held -> sm sequence 0,1,0,1...; add=1 only when sm=1; icount=3 after 6 cycles from FETCH entry.
REQ-034 ir=0x20 (IN), in_valid=0 for 4 EXEC cycles then 1 -> sm=1, in1=1 for 5 cycles, icount +1 only at completion, then FETCH.
REQ-035 ir=0x30 (OUT), out_ready=1 immediately -> one EXEC cycle, out1=1 exactly one cycle.
REQ-036 ir=0x10 (HALT) -> HALTED: halt=1, halted=1, busy=0; toggling run 10 cycles -> no change; rst_n=0 one cycle -> IDLE, icount=0.
REQ-037 run dropped during IN stall -> in1 held until in_valid=1, then IDLE (sm=0, busy=0); run=1 again -> FETCH next cycle.
REQ-038 icount preloaded to 0xFFFF (ICNT_W=16 via long run) -> further completions keep 0xFFFF.

Source files
------------

// File: rtl/instr_seq_pkg.sv
// Shared definitions for the instruction sequencer and its decoder.
// Holds the opcode map (ir[7:4]) and the FSM state encoding.
package instr_seq_pkg;

  localparam int N_OPS = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_HALT = 4'h1;
  localparam logic [3:0] OP_IN   = 4'h2;
  localparam logic [3:0] OP_OUT  = 4'h3;
  localparam logic [3:0] OP_MOVA = 4'h4;
  localparam logic [3:0] OP_MOVB = 4'h5;
  localparam logic [3:0] OP_MOVC = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_ADD  = 4'h9;
  localparam logic [3:0] OP_SUB  = 4'hA;
  localparam logic [3:0] OP_AND  = 4'hB;
  localparam logic [3:0] OP_NOT  = 4'hC;
  localparam logic [3:0] OP_RSR  = 4'hD;
  localparam logic [3:0] OP_RSL  = 4'hE;
  localparam logic [3:0] OP_JC   = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder.
// Ports:
//   op    in  4   opcode (ir[7:4])
//   lines out 16  one-hot instruction lines, bit index == opcode value
module op_decode
  import instr_seq_pkg::*;
(
  input  logic [3:0]       op,
  output logic [N_OPS-1:0] lines
);

  assign lines[OP_NOP]  = (op == OP_NOP);
  assign lines[OP_HALT] = (op == OP_HALT);
  assign lines[OP_IN]   = (op == OP_IN);
  assign lines[OP_OUT]  = (op == OP_OUT);
  assign lines[OP_MOVA] = (op == OP_MOVA);
  assign lines[OP_MOVB] = (op == OP_MOVB);
  assign lines[OP_MOVC] = (op == OP_MOVC);
  assign lines[OP_JMP]  = (op == OP_JMP);
  assign lines[OP_JZ]   = (op == OP_JZ);
  assign lines[OP_ADD]  = (op == OP_ADD);
  assign lines[OP_SUB]  = (op == OP_SUB);
  assign lines[OP_AND]  = (op == OP_AND);
  assign lines[OP_NOT]  = (op == OP_NOT);
  assign lines[OP_RSR]  = (op == OP_RSR);
  assign lines[OP_RSL]  = (op == OP_RSL);
  assign lines[OP_JC]   = (op == OP_JC);

endmodule

// File: rtl/instr_seq.sv
// Instruction sequencer: fetch/execute phase FSM with one-hot instruction
// line generation and a saturating retired-instruction counter.
//
// state  | meaning
// IDLE   | paused, waiting for run=1
// FETCH  | one-cycle fetch phase, ir loads externally on exit edge
// EXEC   | decoded line active; IN/OUT stall until handshake
// HALTED | after HALT; only reset leaves
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   run                 1 = keep sequencing, 0 = pause at instruction boundary
//   ir[7:0]             instruction register (opcode in [7:4])
//   in_valid, out_ready IN/OUT handshakes
//   sm                  0 = fetch phase, 1 = execute phase
//   nop..jc             one-hot instruction lines
//   busy, halted        status
//   icount              retired-instruction count, saturating
module instr_seq
  import instr_seq_pkg::*;
#(
  parameter int ICNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [7:0]        ir,
  input  logic              in_valid,
  input  logic              out_ready,
  output logic              sm,
  output logic              nop,
  output logic              halt,
  output logic              in1,
  output logic              out1,
  output logic              mova,
  output logic              movb,
  output logic              movc,
  output logic              jmp,
  output logic              jz,
  output logic              add,
  output logic              sub,
  output logic              and1,
  output logic              not1,
  output logic              rsr,
  output logic              rsl,
  output logic              jc,
  output logic              busy,
  output logic              halted,
  output logic [ICNT_W-1:0] icount
);

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       op;
  logic [N_OPS-1:0] dec_lines;
  logic [N_OPS-1:0] line_vec;
  logic [N_OPS-1:0] halt_only;
  logic             done;
  logic             retire;
  logic             unused_ir_low;

  assign op            = ir[7:4];
  assign unused_ir_low = ^ir[3:0];
  assign halt_only     = {{(N_OPS-1){1'b0}}, 1'b1} << OP_HALT;

  op_decode u_dec (
    .op    (op),
    .lines (dec_lines)
  );

  // IN and OUT wait on their handshake; everything else finishes in one cycle.
  always_comb begin
    done = 1'b1;
    if (op == OP_IN) begin
      done = in_valid;
    end else if (op == OP_OUT) begin
      done = out_ready;
    end
  end

  assign retire = (state_q == ST_EXEC) && done;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        // run is only consulted at completion, so a pause never aborts an instruction
        if (done) begin
          if (op == OP_HALT)  state_d = ST_HALTED;
          else if (run)       state_d = ST_FETCH;
          else                state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      icount  <= '0;
    end else begin
      state_q <= state_d;
      if (retire && (icount != {ICNT_W{1'b1}})) begin
        icount <= icount + {{(ICNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Lines depend only on registered state and ir, so they are stable per cycle.
  always_comb begin
    line_vec = '0;
    if (state_q == ST_EXEC) begin
      line_vec = dec_lines;
    end else if (state_q == ST_HALTED) begin
      line_vec = halt_only;
    end
  end

  assign sm     = (state_q == ST_EXEC) || (state_q == ST_HALTED);
  assign busy   = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign halted = (state_q == ST_HALTED);

  assign nop  = line_vec[OP_NOP];
  assign halt = line_vec[OP_HALT];
  assign in1  = line_vec[OP_IN];
  assign out1 = line_vec[OP_OUT];
  assign mova = line_vec[OP_MOVA];
  assign movb = line_vec[OP_MOVB];
  assign movc = line_vec[OP_MOVC];
  assign jmp  = line_vec[OP_JMP];
  assign jz   = line_vec[OP_JZ];
  assign add  = line_vec[OP_ADD];
  assign sub  = line_vec[OP_SUB];
  assign and1 = line_vec[OP_AND];
  assign not1 = line_vec[OP_NOT];
  assign rsr  = line_vec[OP_RSR];
  assign rsl  = line_vec[OP_RSL];
  assign jc   = line_vec[OP_JC];

endmodule

// File: tb/tb_instr_seq.sv
// Scoreboard bench for instr_seq. The driver pushes one expectation per
// instruction (line pattern, EXEC length, state after completion, icount);
// a negedge monitor pops it when the DUT enters EXEC and checks it.
module tb_instr_seq;

  localparam int W    = 8;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run = 1'b0;
  logic [7:0]   ir = 8'h00;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         sm, busy, halted;
  logic         nop, halt, in1, out1, mova, movb, movc, jmp;
  logic         jz, add, sub, and1, not1, rsr, rsl, jc;
  logic [W-1:0] icount;
  logic [15:0]  lines;

  assign lines = {jc, rsl, rsr, not1, and1, sub, add, jz,
                  jmp, movc, movb, mova, out1, in1, halt, nop};

  instr_seq #(.ICNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ir(ir),
    .in_valid(in_valid), .out_ready(out_ready), .sm(sm),
    .nop(nop), .halt(halt), .in1(in1), .out1(out1), .mova(mova),
    .movb(movb), .movc(movc), .jmp(jmp), .jz(jz), .add(add), .sub(sub),
    .and1(and1), .not1(not1), .rsr(rsr), .rsl(rsl), .jc(jc),
    .busy(busy), .halted(halted), .icount(icount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] onehot;
    int          len;
    int          post;   // 0 idle, 1 fetch, 2 halted
    int          cnt;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;
  int   errors = 0;
  int   checks = 0;
  int   exp_cnt = 0;
  bit   mon_en = 1'b0;
  bit   in_exec = 1'b0;
  int   exec_len = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int post_cat();
    if (halted)          return 2;
    if (busy && !sm)     return 1;
    if (!busy && !sm)    return 0;
    return 3;
  endfunction

  // monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        in_exec = 1'b0;
      end else if (sm && busy) begin
        if (!in_exec) begin
          in_exec  = 1'b1;
          exec_len = 0;
          if (sbq.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL sb_underflow: EXEC entered with no expectation at %0t", $time);
            cur.onehot = '0; cur.len = 0; cur.post = 3; cur.cnt = -1;
          end else begin
            cur = sbq.pop_front();
          end
        end
        exec_len++;
        check("exec_lines", lines, cur.onehot);
      end else if (in_exec) begin
        in_exec = 1'b0;
        check("exec_len", exec_len, cur.len);
        check("icount", icount, cur.cnt);
        check("post_state", post_cat(), cur.post);
      end
    end
  end

  // Drive one instruction through EXEC; called at posedge+1 with DUT in IDLE or FETCH.
  task automatic issue(input logic [3:0] op, input int stall_in,
                       input bit run_during, input bit run_after);
    exp_t e;
    int   waited;
    int   stall;
    stall     = (op == 4'h2 || op == 4'h3) ? stall_in : 0;
    ir        = {op, 4'($urandom)};
    run       = 1'b1;
    in_valid  = (op == 4'h2) ? 1'b0 : 1'($urandom);
    out_ready = (op == 4'h3) ? 1'b0 : 1'($urandom);
    exp_cnt   = (exp_cnt < MAXC) ? exp_cnt + 1 : MAXC;
    e.onehot  = 16'h0001 << op;
    e.len     = stall + 1;
    e.post    = (op == 4'h1) ? 2 : (run_after ? 1 : 0);
    e.cnt     = exp_cnt;
    sbq.push_back(e);
    waited = 0;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (!(sm && busy) && waited < 6);
    if (!(sm && busy)) begin
      errors++;
      checks++;
      $display("FAIL exec_entry: no EXEC within %0d cycles, op=%0h", waited, op);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      if (i == stall / 2) run = run_during;
      @(posedge clk); #1;
    end
    if (op == 4'h2) in_valid = 1'b1;
    if (op == 4'h3) out_ready = 1'b1;
    run = run_after;
    @(posedge clk); #1;
    if (op == 4'h2) in_valid = 1'b0;
    if (op == 4'h3) out_ready = 1'b0;
  endtask

  task automatic summary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    summary();
    $finish;
  end

  initial begin
    logic [3:0] op;
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_sm", sm, 0);
    check("rst_lines", lines, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_icount", icount, 0);
    rst_n   = 1'b1;
    exp_cnt = 0;
    mon_en  = 1'b1;

    // three ADDs back to back
    for (int i = 0; i < 3; i++) issue(4'h9, 0, 1'b1, 1'b1);
    check("add_icount3", icount, 3);

    // IN with 4 stall cycles, OUT with immediate ready
    issue(4'h2, 4, 1'b1, 1'b1);
    issue(4'h3, 0, 1'b1, 1'b1);

    // run dropped during IN stall -> IDLE, then run=1 -> FETCH next cycle
    issue(4'h2, 3, 1'b0, 1'b0);
    check("pause_busy", busy, 0);
    check("pause_sm", sm, 0);
    run = 1'b1;
    @(posedge clk); #1;
    check("resume_fetch", post_cat(), 1);

    // randomized mix (no HALT)
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h1) op = 4'h0;
      issue(op, $urandom_range(0, 4), 1'($urandom), $urandom_range(0, 3) != 0);
    end

    // drive the counter into saturation
    for (int n = 0; n < MAXC + 8; n++) issue(4'($urandom_range(4, 15)), 0, 1'b1, 1'b1);
    check("sat_icount", icount, MAXC);

    // reset mid-stall, with all other inputs asserted on the same edge
    mon_en    = 1'b0;
    ir        = 8'h20;
    in_valid  = 1'b0;
    run       = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("stall_in1", in1, 1);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("midrst_sm", sm, 0);
    check("midrst_busy", busy, 0);
    check("midrst_lines", lines, 0);
    check("midrst_icount", icount, 0);
    rst_n     = 1'b1;
    run       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_cnt   = 0;
    @(posedge clk); #1;
    mon_en = 1'b1;

    // HALT, then run toggling has no effect
    issue(4'h1, 0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      run = ~run;
      @(posedge clk); #1;
      check("halt_halted", halted, 1);
      check("halt_busy", busy, 0);
      check("halt_sm", sm, 1);
      check("halt_lines", lines, 16'h0002);
      check("halt_icount", icount, exp_cnt);
    end
    rst_n = 1'b0;
    run   = 1'b1;
    @(posedge clk); #1;
    check("halt_rst_state", post_cat(), 0);
    check("halt_rst_icount", icount, 0);
    rst_n = 1'b1;
    run   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", sbq.size(), 0);
    summary();
    $finish;
  end

endmodule
